// File: rtl/sdram_block_responder.sv
// sdram_block_responder: backing store plus block-refill engine for the icache.
// A read request is accepted in IDLE. After a fixed first-word latency, one full
// block is streamed one word per cycle. The critical word comes first and the
// word index wraps within the aligned block.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for readRequest; outputs quiet
//   LATENCY | first-word latency down-counter running
//   BURST   | a beat is on dataOut; beatsLeft counts the beats still to come
module sdram_block_responder #(
    parameter int BLOCK_WORDS   = 4,
    parameter int WORD_SIZE     = 32,
    parameter int MEM_WORDS     = 4096,
    parameter int FIRST_LATENCY = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           readRequest,
    input  logic [31:0]                    readAddress,
    output logic [WORD_SIZE-1:0]           dataOut,
    output logic                           dataReady,
    output logic [$clog2(BLOCK_WORDS)-1:0] blockIndex,
    output logic                           busy,
    input  logic                           wrEnable,
    input  logic [31:0]                    wrAddress,
    input  logic [WORD_SIZE-1:0]           wrData
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int ADDR_W = $clog2(MEM_WORDS);
    localparam int BLK_W = ADDR_W - IDX_W;
    // The counter is loaded with FIRST_LATENCY-2, so it never needs more than clog2(FIRST_LATENCY-1) bits.
    localparam int LAT_W = (FIRST_LATENCY > 2) ? $clog2(FIRST_LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LATENCY = 2'd1,
        BURST   = 2'd2
    } state_t;

    state_t state, nextState;

    logic [WORD_SIZE-1:0] mem [MEM_WORDS];

    logic [LAT_W-1:0] latCnt, latCntNext;
    logic [IDX_W-1:0] beatsLeft, beatsLeftNext;
    logic [BLK_W-1:0] baseBlk;
    logic [IDX_W-1:0] startIdx;

    logic             captureReq;
    logic             loadBeat;
    logic             endBurst;
    logic [IDX_W-1:0] beatIdx;
    logic [BLK_W-1:0] beatBase;

    // Only the in-range word-address bits matter. Higher bits alias, and the byte offset is dropped.
    logic [IDX_W-1:0]  reqIdx;
    logic [BLK_W-1:0]  reqBlk;
    logic [ADDR_W-1:0] wrWord;
    logic              unusedAddrBits;

    assign reqIdx = readAddress[IDX_W+1:2];
    assign reqBlk = readAddress[ADDR_W+1:IDX_W+2];
    assign wrWord = wrAddress[ADDR_W+1:2];
    assign unusedAddrBits = ^{readAddress[31:ADDR_W+2], readAddress[1:0],
                              wrAddress[31:ADDR_W+2], wrAddress[1:0]};

    // Next-state logic, counter updates and the beat-load decision.
    always_comb begin
        nextState     = state;
        latCntNext    = latCnt;
        beatsLeftNext = beatsLeft;
        captureReq    = 1'b0;
        loadBeat      = 1'b0;
        endBurst      = 1'b0;
        beatIdx       = blockIndex + 1'b1;
        beatBase      = baseBlk;
        case (state)
            IDLE: begin
                if (readRequest) begin
                    captureReq = 1'b1;
                    if (FIRST_LATENCY == 1) begin
                        // With a latency of one, the acceptance edge also loads beat 0.
                        loadBeat      = 1'b1;
                        beatIdx       = reqIdx;
                        beatBase      = reqBlk;
                        beatsLeftNext = IDX_W'(BLOCK_WORDS - 1);
                        nextState     = BURST;
                    end else begin
                        latCntNext = LAT_W'(FIRST_LATENCY - 2);
                        nextState  = LATENCY;
                    end
                end
            end
            LATENCY: begin
                if (latCnt == '0) begin
                    loadBeat      = 1'b1;
                    beatIdx       = startIdx;
                    beatsLeftNext = IDX_W'(BLOCK_WORDS - 1);
                    nextState     = BURST;
                end else begin
                    latCntNext = latCnt - 1'b1;
                end
            end
            BURST: begin
                if (beatsLeft == '0) begin
                    endBurst  = 1'b1;
                    nextState = IDLE;
                end else begin
                    loadBeat      = 1'b1;
                    beatsLeftNext = beatsLeft - 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State, counter and captured-request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            latCnt    <= '0;
            beatsLeft <= '0;
            baseBlk   <= '0;
            startIdx  <= '0;
        end else begin
            state     <= nextState;
            latCnt    <= latCntNext;
            beatsLeft <= beatsLeftNext;
            if (captureReq) begin
                baseBlk  <= reqBlk;
                startIdx <= reqIdx;
            end
        end
    end

    // Registered outputs. Beat data reads the array before any write at the same edge takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut    <= '0;
            dataReady  <= 1'b0;
            blockIndex <= '0;
            busy       <= 1'b0;
        end else begin
            busy <= (nextState != IDLE);
            if (loadBeat) begin
                dataReady  <= 1'b1;
                blockIndex <= beatIdx;
                dataOut    <= mem[{beatBase, beatIdx}];
            end else if (endBurst) begin
                dataReady  <= 1'b0;
                blockIndex <= '0;
                dataOut    <= '0;
            end
        end
    end

    // Backing-store write port. It is live in every state and ignores reset, so contents survive it.
    always_ff @(posedge clk) begin
        if (wrEnable) begin
            mem[wrWord] <= wrData;
        end
    end

endmodule

// File: tb/tb_sdram_block_responder.sv
// Bench for sdram_block_responder.
// The reference model works at transaction level. It tracks the acceptance
// edge of each request and derives every beat from it:
//   beat k is loaded at edge accept+L-1+k,
//   its index is (start+k) mod BW,
//   its data is the model memory as it stood before that edge's write.
// The model pushes each beat into a queue. A negedge monitor pops the queue
// and compares whenever the DUT shows dataReady.
module tb_sdram_block_responder;

    localparam int BW = 4;
    localparam int WS = 32;
    localparam int MW = 4096;
    localparam int L  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          readRequest = 1'b0;
    logic [31:0]   readAddress = '0;
    logic          wrEnable = 1'b0;
    logic [31:0]   wrAddress = '0;
    logic [WS-1:0] wrData = '0;
    logic [WS-1:0] dataOut;
    logic          dataReady;
    logic [1:0]    blockIndex;
    logic          busy;

    sdram_block_responder #(
        .BLOCK_WORDS(BW), .WORD_SIZE(WS), .MEM_WORDS(MW), .FIRST_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .readRequest(readRequest), .readAddress(readAddress),
        .dataOut(dataOut), .dataReady(dataReady), .blockIndex(blockIndex), .busy(busy),
        .wrEnable(wrEnable), .wrAddress(wrAddress), .wrData(wrData)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [WS-1:0] data;
    } beat_t;

    beat_t         expQ[$];
    logic [WS-1:0] refMem [MW];
    int            edgeNum = 0;
    bit            active = 0;
    int            acceptEdge = 0;
    int            startIdx = 0;
    int            baseWord = 0;
    bit            expBusy = 0;
    bit            rstChk = 0;
    bit            started = 0;
    int            checks = 0;
    int            failures = 0;

    // Model step for the edge that has just occurred. The inputs are still the values sampled at that edge.
    task automatic modelEdge();
        int    k;
        int    w;
        int    idx;
        beat_t b;
        rstChk = reset;
        if (reset) begin
            active = 0;
        end else begin
            if (!active && readRequest) begin
                active     = 1;
                acceptEdge = edgeNum;
                w          = int'(readAddress >> 2) % MW;
                baseWord   = w - (w % BW);
                startIdx   = w % BW;
            end
            if (active) begin
                k = edgeNum - (acceptEdge + L - 1);
                if (k >= 0 && k < BW) begin
                    idx    = (startIdx + k) % BW;
                    b.idx  = idx;
                    b.data = refMem[baseWord + idx];
                    expQ.push_back(b);
                end
                if (edgeNum == acceptEdge + L - 1 + BW) active = 0;
            end
        end
        expBusy = active;
        if (wrEnable) refMem[int'(wrAddress >> 2) % MW] = wrData;
        edgeNum++;
        started = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [WS-1:0] d);
        wrEnable  = 1'b1;
        wrAddress = a;
        wrData    = d;
        tick();
        wrEnable  = 1'b0;
    endtask

    task automatic request(input logic [31:0] a);
        readRequest = 1'b1;
        readAddress = a;
        tick();
        readRequest = 1'b0;
    endtask

    // Monitor: compares dataReady and busy on every cycle, and checks each beat's index and data.
    always @(negedge clk) begin : monitor
        beat_t b;
        logic  expReady;
        if (started) begin
            expReady = (expQ.size() != 0);
            checks++;
            if (dataReady !== expReady) begin
                failures++;
                $display("FAIL dataReady edge %0d: got %b expected %b", edgeNum - 1, dataReady, expReady);
            end
            if (expReady) begin
                b = expQ.pop_front();
                if (dataReady === 1'b1) begin
                    checks++;
                    if (blockIndex !== 2'(b.idx)) begin
                        failures++;
                        $display("FAIL blockIndex edge %0d: got %0d expected %0d", edgeNum - 1, blockIndex, b.idx);
                    end
                    checks++;
                    if (dataOut !== b.data) begin
                        failures++;
                        $display("FAIL dataOut edge %0d idx %0d: got %h expected %h", edgeNum - 1, b.idx, dataOut, b.data);
                    end
                end
            end
            checks++;
            if (busy !== expBusy) begin
                failures++;
                $display("FAIL busy edge %0d: got %b expected %b", edgeNum - 1, busy, expBusy);
            end
            if (rstChk) begin
                checks++;
                if (blockIndex !== 2'd0) begin
                    failures++;
                    $display("FAIL resetIndex edge %0d: got %0d expected 0", edgeNum - 1, blockIndex);
                end
                checks++;
                if (dataOut !== '0) begin
                    failures++;
                    $display("FAIL resetData edge %0d: got %h expected 0", edgeNum - 1, dataOut);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // Fill words 0..0x4F, then place A0..A3 at 0x100..0x10C.
        for (int i = 0; i < 'h50; i++) wr(32'(i * 4), $urandom);
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i));

        // Aligned burst, then critical word first.
        request(32'h100);  idle(14);
        request(32'h108);  idle(14);

        // Held request: two bursts. A pulse during the second latency is dropped.
        readRequest = 1'b1;
        readAddress = 32'h100;
        idle(13);
        readRequest = 1'b0;
        idle(2);
        request(32'h100);
        idle(14);

        // Reset while beat 2 is on the bus, then a clean burst.
        request(32'h100);
        idle(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle(2);
        request(32'h100);  idle(14);

        // Write race: one write during LATENCY, one at the edge that loads beat 3.
        request(32'h100);
        idle(2);
        wr(32'h10C, 32'hB300_0003);
        idle(6);
        wr(32'h10C, 32'hC300_0003);
        idle(2);
        request(32'h100);  idle(14);

        // Aliasing through the address bits above the array.
        request(32'h4100);      idle(14);
        request(32'hABCD_C10B); idle(14);

        // Random traffic: requests, writes and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            readRequest = ($urandom_range(0, 3) == 0);
            readAddress = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 'h4F)) << 2)
                          | 32'($urandom_range(0, 3));
            wrEnable    = ($urandom_range(0, 3) == 0);
            wrAddress   = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 'h4F)) << 2);
            wrData      = $urandom;
            reset       = ($urandom_range(0, 199) == 0);
            tick();
        end
        readRequest = 1'b0;
        wrEnable    = 1'b0;
        reset       = 1'b0;
        idle(16);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
